// File: rtl/cp0_pkg.sv
// Shared encodings for the nested-interrupt coprocessor 0: operations, register map,
// cause codes, status/cause field positions and the redirect FSM states.
package cp0_pkg;

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_MTC  = 3'd1;
    localparam logic [2:0] OP_MFC  = 3'd2;
    localparam logic [2:0] OP_ERET = 3'd3;

    localparam logic [4:0] REG_EHB    = 5'd3;
    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;
    localparam logic [4:0] REG_LEVEL  = 5'd15;

    localparam int unsigned EXC_UNDEFINED    = 1;
    localparam int unsigned EXC_OVERFLOW     = 2;
    localparam int unsigned EXC_OUT_OF_RANGE = 4;

    localparam int unsigned STATUS_IE_BIT = 0;
    localparam int unsigned STATUS_IM_LSB = 8;
    localparam int unsigned CAUSE_IP_LSB  = 8;
    localparam int unsigned LEVEL_W       = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_REDIR = 1'b1
    } cp0_state_e;

endpackage

// File: rtl/cp0_epc_stack.sv
// Return-address/level LIFO; a push while full may replace the top entry instead of
// being dropped, and the entry under the top is exposed so eret can restore EPC.
module cp0_epc_stack #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     ovw_on_full,
    input  logic                     wr_top,
    input  logic [DATA_W-1:0]        push_addr,
    input  logic [3:0]               push_level,
    input  logic [DATA_W-1:0]        wr_top_addr,
    output logic [DATA_W-1:0]        top_addr,
    output logic [3:0]               top_level,
    output logic [DATA_W-1:0]        below_addr,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] addr_q [DEPTH];
    logic [3:0]        lvl_q  [DEPTH];
    logic [PTR_W:0]    sp_q;
    logic [PTR_W-1:0]  top_idx;
    logic [PTR_W-1:0]  below_idx;

    assign top_idx    = PTR_W'(sp_q - (PTR_W+1)'(1));
    assign below_idx  = PTR_W'(sp_q - (PTR_W+1)'(2));
    assign full       = (sp_q == (PTR_W+1)'(DEPTH));
    assign empty      = (sp_q == '0);
    assign depth      = sp_q;
    assign top_addr   = empty ? '0 : addr_q[top_idx];
    assign top_level  = empty ? '0 : lvl_q[top_idx];
    assign below_addr = (sp_q < (PTR_W+1)'(2)) ? '0 : addr_q[below_idx];

    // Push has priority; the top only moves when storage actually changes depth
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                lvl_q[i]  <= '0;
            end
        end else if (push) begin
            if (!full) begin
                addr_q[sp_q[PTR_W-1:0]] <= push_addr;
                lvl_q[sp_q[PTR_W-1:0]]  <= push_level;
                sp_q                    <= sp_q + (PTR_W+1)'(1);
            end else if (ovw_on_full) begin
                addr_q[top_idx] <= push_addr;
                lvl_q[top_idx]  <= push_level;
            end
        end else if (pop && !empty) begin
            sp_q <= sp_q - (PTR_W+1)'(1);
        end else if (wr_top && !empty) begin
            addr_q[top_idx] <= wr_top_addr;
        end
    end

endmodule

// File: rtl/cp0_nested_irq.sv
// Coprocessor 0 with prioritised nested interrupts: register file, trap/eret
// sequencing through a one-cycle redirect state, and the return LIFO.
module cp0_nested_irq
    import cp0_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       NUM_IRQ   = 3,
    parameter int unsigned       NEST_DEPTH = 4,
    parameter logic [DATA_W-1:0] EHB_RESET = 32'h0000_0024,
    parameter int unsigned       EXC_W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         cp_oper,
    input  logic [4:0]         addr_r,
    output logic [DATA_W-1:0]  data_readFromCP0,
    input  logic [4:0]         addr_w,
    input  logic [DATA_W-1:0]  data_writeToCP0,
    input  logic [EXC_W-1:0]   cause,
    input  logic [NUM_IRQ-1:0] interruptSignal,
    input  logic [DATA_W-1:0]  except_ret_addr,
    output logic               epc_ctrl,
    output logic [DATA_W-1:0]  jumpAddressExcept,
    output logic               exceptClear,
    output logic [3:0]         cur_level,
    output logic               nest_overflow
);
    localparam int unsigned   DEPTH_W   = $clog2(NEST_DEPTH) + 1;
    localparam logic [3:0]    EXC_LEVEL = 4'(NUM_IRQ + 1);

    cp0_state_e        state_q, state_d;
    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] regs_d [32];
    logic              epc_q, epc_d, clr_q, clr_d, ovf_q, ovf_d;
    logic [DATA_W-1:0] jump_q, jump_d, rd_q, rd_d;
    logic [3:0]        level_q, level_d;

    logic               ie;
    logic [NUM_IRQ-1:0] pend;
    logic [3:0]         irq_lvl;
    logic               take_exc, take_irq, take_eret;
    logic [DATA_W-1:0]  rd_val, cause_w;

    logic               stk_push, stk_pop, stk_wr_top, stk_full, stk_empty;
    logic [DATA_W-1:0]  stk_top_addr, stk_below_addr;
    logic [3:0]         stk_top_level;
    logic [DEPTH_W-1:0] stk_depth;

    cp0_epc_stack #(.DATA_W(DATA_W), .DEPTH(NEST_DEPTH)) u_stack (
        .clk         (clk),
        .rst         (rst),
        .push        (stk_push),
        .pop         (stk_pop),
        .ovw_on_full (take_exc),
        .wr_top      (stk_wr_top),
        .push_addr   (except_ret_addr),
        .push_level  (level_q),
        .wr_top_addr (data_writeToCP0),
        .top_addr    (stk_top_addr),
        .top_level   (stk_top_level),
        .below_addr  (stk_below_addr),
        .depth       (stk_depth),
        .full        (stk_full),
        .empty       (stk_empty)
    );

    assign ie   = regs_q[REG_STATUS][STATUS_IE_BIT];
    assign pend = interruptSignal & regs_q[REG_STATUS][STATUS_IM_LSB +: NUM_IRQ] & {NUM_IRQ{ie}};

    // Highest pending line wins; line k maps to level k+1
    always_comb begin
        irq_lvl = '0;
        for (int k = 0; k < int'(NUM_IRQ); k++) begin
            if (pend[k]) irq_lvl = 4'(k + 1);
        end
    end

    assign take_exc  = (state_q == ST_RUN) && (cause != '0) && ie;
    assign take_irq  = (state_q == ST_RUN) && !take_exc && (irq_lvl > level_q) && !stk_full;
    assign take_eret = (state_q == ST_RUN) && !take_exc && !take_irq && (cp_oper == OP_ERET);

    assign rd_val = (addr_r == REG_LEVEL) ? DATA_W'({ovf_q, stk_depth, level_q}) : regs_q[addr_r];

    always_comb begin
        cause_w = '0;
        cause_w[CAUSE_IP_LSB +: NUM_IRQ] = interruptSignal;
        if (take_exc) cause_w[EXC_W-1:0] = cause;
        else          cause_w[DATA_W-1]  = 1'b1;
    end

    always_comb begin
        regs_d     = regs_q;
        state_d    = ST_RUN;
        epc_d      = 1'b0;
        clr_d      = 1'b0;
        jump_d     = jump_q;
        level_d    = level_q;
        ovf_d      = ovf_q;
        rd_d       = rd_q;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_wr_top = 1'b0;

        if (cp_oper == OP_MFC) rd_d = rd_val;

        // Software writes first so that same-cycle trap updates override them
        if (cp_oper == OP_MTC && addr_w != REG_LEVEL) begin
            regs_d[addr_w] = data_writeToCP0;
            if (addr_w == REG_CAUSE) ovf_d = 1'b0;
            if (addr_w == REG_EPC && !take_exc && !take_irq) stk_wr_top = 1'b1;
        end

        if (take_exc || take_irq) begin
            stk_push          = 1'b1;
            regs_d[REG_EPC]   = except_ret_addr;
            regs_d[REG_CAUSE] = cause_w;
            level_d           = take_exc ? EXC_LEVEL : irq_lvl;
            jump_d            = regs_q[REG_EHB];
            epc_d             = 1'b1;
            clr_d             = 1'b1;
            state_d           = ST_REDIR;
            if (take_exc && stk_full) ovf_d = 1'b1;
        end else if (take_eret) begin
            stk_pop = 1'b1;
            epc_d   = 1'b1;
            state_d = ST_REDIR;
            if (!stk_empty) begin
                jump_d          = stk_top_addr;
                level_d         = stk_top_level;
                regs_d[REG_EPC] = stk_below_addr;
            end else begin
                jump_d  = regs_q[REG_EPC];
                level_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (5'(i) == REG_EHB) ? EHB_RESET : '0;
            end
            epc_q   <= 1'b0;
            clr_q   <= 1'b0;
            jump_q  <= EHB_RESET;
            level_q <= '0;
            ovf_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            epc_q   <= epc_d;
            clr_q   <= clr_d;
            jump_q  <= jump_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            rd_q    <= rd_d;
        end
    end

    assign data_readFromCP0  = rd_q;
    assign epc_ctrl          = epc_q;
    assign exceptClear       = clr_q;
    assign jumpAddressExcept = jump_q;
    assign cur_level         = level_q;
    assign nest_overflow     = ovf_q;

endmodule

// File: tb/tb_cp0_nested_irq.sv
// Vector table plus hand-written nesting, overflow and reset sequences for cp0_nested_irq.
module tb_cp0_nested_irq;
    import cp0_pkg::*;

    typedef struct {
        logic        rst;
        logic [2:0]  op;
        logic [4:0]  ra;
        logic [31:0] wd;
        logic [2:0]  cs;
        logic [2:0]  irq;
        logic [31:0] ret;
        logic        e_epc;
        logic        e_clr;
        logic [31:0] e_jump;
        logic [3:0]  e_lvl;
        logic        e_ovf;
        logic        chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cp_oper;
    logic [4:0]  addr_r, addr_w;
    logic [31:0] data_readFromCP0, data_writeToCP0, except_ret_addr, jumpAddressExcept;
    logic [2:0]  cause, interruptSignal;
    logic        epc_ctrl, exceptClear, nest_overflow;
    logic [3:0]  cur_level;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   vnum     = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    cp0_nested_irq dut (
        .clk               (clk),
        .rst               (rst),
        .cp_oper           (cp_oper),
        .addr_r            (addr_r),
        .data_readFromCP0  (data_readFromCP0),
        .addr_w            (addr_w),
        .data_writeToCP0   (data_writeToCP0),
        .cause             (cause),
        .interruptSignal   (interruptSignal),
        .except_ret_addr   (except_ret_addr),
        .epc_ctrl          (epc_ctrl),
        .jumpAddressExcept (jumpAddressExcept),
        .exceptClear       (exceptClear),
        .cur_level         (cur_level),
        .nest_overflow     (nest_overflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [2:0] op, input logic [4:0] ra,
                                input logic [31:0] wd, input logic [2:0] cs, input logic [2:0] irq,
                                input logic [31:0] ret, input logic e_epc, input logic e_clr,
                                input logic [31:0] e_jump, input logic [3:0] e_lvl, input logic e_ovf,
                                input logic chk_rd, input logic [31:0] e_rd);
        vec_t v;
        v.rst = r; v.op = op; v.ra = ra; v.wd = wd; v.cs = cs; v.irq = irq; v.ret = ret;
        v.e_epc = e_epc; v.e_clr = e_clr; v.e_jump = e_jump; v.e_lvl = e_lvl; v.e_ovf = e_ovf;
        v.chk_rd = chk_rd; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h expected %h", vnum, name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic apply(input vec_t v);
        vec_t e;
        rst = v.rst; cp_oper = v.op; addr_r = v.ra; addr_w = v.ra; data_writeToCP0 = v.wd;
        cause = v.cs; interruptSignal = v.irq; except_ret_addr = v.ret;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("epc_ctrl", 32'(epc_ctrl), 32'(e.e_epc));
        chk("exceptClear", 32'(exceptClear), 32'(e.e_clr));
        chk("jumpAddressExcept", jumpAddressExcept, e.e_jump);
        chk("cur_level", 32'(cur_level), 32'(e.e_lvl));
        chk("nest_overflow", 32'(nest_overflow), 32'(e.e_ovf));
        if (e.chk_rd) chk("data_readFromCP0", data_readFromCP0, e.e_rd);
        vnum++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] c_ov, c_ud, c_oor;
        c_ov  = 3'(EXC_OVERFLOW);
        c_ud  = 3'(EXC_UNDEFINED);
        c_oor = 3'(EXC_OUT_OF_RANGE);

        // reset, basic access, two-level nesting and unwind
        tbl.push_back(mk(1, OP_NONE, 5'd0,  32'h0,   3'd0, 3'b000, 32'h0,   0, 0, 32'h24,  4'd0, 0, 1, 32'h0));
        tbl.push_back(mk(1, OP_NONE, 5'd0,  32'h0,   3'd0, 3'b000, 32'h0,   0, 0, 32'h24,  4'd0, 0, 1, 32'h0));
        tbl.push_back(mk(0, OP_MFC,  REG_EHB,    32'h0,   3'd0, 3'b000, 32'h0, 0, 0, 32'h24, 4'd0, 0, 1, 32'h24));
        tbl.push_back(mk(0, OP_MTC,  REG_STATUS, 32'h701, 3'd0, 3'b000, 32'h0, 0, 0, 32'h24, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MFC,  REG_STATUS, 32'h0,   3'd0, 3'b000, 32'h0, 0, 0, 32'h24, 4'd0, 0, 1, 32'h701));
        tbl.push_back(mk(0, OP_NONE, 5'd0,  32'h0,   3'd0, 3'b001, 32'h100, 1, 1, 32'h24,  4'd1, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_ERET, 5'd0,  32'h0,   3'd0, 3'b000, 32'h0,   0, 0, 32'h24,  4'd1, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MFC,  REG_EPC,    32'h0,   3'd0, 3'b000, 32'h0, 0, 0, 32'h24, 4'd1, 0, 1, 32'h100));
        tbl.push_back(mk(0, OP_NONE, 5'd0,  32'h0,   3'd0, 3'b100, 32'h200, 1, 1, 32'h24,  4'd3, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MFC,  REG_CAUSE,  32'h0,   3'd0, 3'b000, 32'h0, 0, 0, 32'h24, 4'd3, 0, 1, 32'h8000_0400));
        tbl.push_back(mk(0, OP_MFC,  REG_LEVEL,  32'h0,   3'd0, 3'b000, 32'h0, 0, 0, 32'h24, 4'd3, 0, 1, 32'h23));
        tbl.push_back(mk(0, OP_ERET, 5'd0,  32'h0,   3'd0, 3'b000, 32'h0,   1, 0, 32'h200, 4'd1, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MFC,  REG_EPC,    32'h0,   3'd0, 3'b000, 32'h0, 0, 0, 32'h200, 4'd1, 0, 1, 32'h100));
        tbl.push_back(mk(0, OP_ERET, 5'd0,  32'h0,   3'd0, 3'b000, 32'h0,   1, 0, 32'h100, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MFC,  REG_EPC,    32'h0,   3'd0, 3'b000, 32'h0, 0, 0, 32'h100, 4'd0, 0, 1, 32'h0));
        // lower-priority line blocked, exception wins, cause in redirect ignored
        tbl.push_back(mk(0, OP_NONE, 5'd0,  32'h0,   3'd0, 3'b100, 32'h200, 1, 1, 32'h24,  4'd3, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_NONE, 5'd0,  32'h0,   3'd0, 3'b000, 32'h0,   0, 0, 32'h24,  4'd3, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_NONE, 5'd0,  32'h0,   c_ov, 3'b010, 32'h300, 1, 1, 32'h24,  4'd4, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_NONE, 5'd0,  32'h0,   c_ud, 3'b010, 32'h999, 0, 0, 32'h24,  4'd4, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MFC,  REG_CAUSE,  32'h0,   3'd0, 3'b000, 32'h0, 0, 0, 32'h24, 4'd4, 0, 1, 32'h202));
        tbl.push_back(mk(0, OP_MFC,  REG_EPC,    32'h0,   3'd0, 3'b000, 32'h0, 0, 0, 32'h24, 4'd4, 0, 1, 32'h300));
        tbl.push_back(mk(0, OP_ERET, 5'd0,  32'h0,   3'd0, 3'b000, 32'h0,   1, 0, 32'h300, 4'd3, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MFC,  REG_EPC,    32'h0,   3'd0, 3'b000, 32'h0, 0, 0, 32'h300, 4'd3, 0, 1, 32'h200));
        tbl.push_back(mk(0, OP_ERET, 5'd0,  32'h0,   3'd0, 3'b000, 32'h0,   1, 0, 32'h200, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MFC,  REG_LEVEL,  32'h0,   3'd0, 3'b000, 32'h0, 0, 0, 32'h200, 4'd0, 0, 1, 32'h0));
        // masking and global enable
        tbl.push_back(mk(0, OP_MTC,  REG_STATUS, 32'h501, 3'd0, 3'b000, 32'h0,   0, 0, 32'h200, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_NONE, 5'd0,       32'h0,   3'd0, 3'b010, 32'h0,   0, 0, 32'h200, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MTC,  REG_STATUS, 32'h0,   3'd0, 3'b000, 32'h0,   0, 0, 32'h200, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_NONE, 5'd0,       32'h0,   c_ud, 3'b111, 32'h777, 0, 0, 32'h200, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MTC,  REG_STATUS, 32'h701, 3'd0, 3'b000, 32'h0,   0, 0, 32'h200, 4'd0, 0, 0, 32'h0));
        // eret with empty LIFO, trap overriding mtc EPC, mtc EPC rewriting the LIFO top
        tbl.push_back(mk(0, OP_MTC,  REG_EPC,    32'h444, 3'd0, 3'b000, 32'h0,   0, 0, 32'h200, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_ERET, 5'd0,       32'h0,   3'd0, 3'b000, 32'h0,   1, 0, 32'h444, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MTC,  REG_EPC,    32'h555, 3'd0, 3'b001, 32'h100, 0, 0, 32'h444, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MTC,  REG_EPC,    32'h666, 3'd0, 3'b001, 32'h100, 1, 1, 32'h24,  4'd1, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MFC,  REG_EPC,    32'h0,   3'd0, 3'b000, 32'h0,   0, 0, 32'h24,  4'd1, 0, 1, 32'h100));
        tbl.push_back(mk(0, OP_MTC,  REG_EPC,    32'h180, 3'd0, 3'b000, 32'h0,   0, 0, 32'h24,  4'd1, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_ERET, 5'd0,       32'h0,   3'd0, 3'b000, 32'h0,   1, 0, 32'h180, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MFC,  REG_EPC,    32'h0,   3'd0, 3'b000, 32'h0,   0, 0, 32'h180, 4'd0, 0, 1, 32'h0));
        // relocated handler base
        tbl.push_back(mk(0, OP_MTC,  REG_EHB,    32'h80,  3'd0, 3'b000, 32'h0,   0, 0, 32'h180, 4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_NONE, 5'd0,       32'h0,   3'd0, 3'b001, 32'h10,  1, 1, 32'h80,  4'd1, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_NONE, 5'd0,       32'h0,   3'd0, 3'b000, 32'h0,   0, 0, 32'h80,  4'd1, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_ERET, 5'd0,       32'h0,   3'd0, 3'b000, 32'h0,   1, 0, 32'h10,  4'd0, 0, 0, 32'h0));
        tbl.push_back(mk(0, OP_MFC,  REG_EHB,    32'h0,   3'd0, 3'b000, 32'h0,   0, 0, 32'h10,  4'd0, 0, 1, 32'h80));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // LIFO fill, overwrite-on-full exception, sticky overflow cleared by mtc CAUSE
        for (int i = 0; i < 4; i++) begin
            apply(mk(0, OP_NONE, 5'd0, 32'h0, c_oor, 3'b000, 32'h1000 + 32'(i), 1, 1, 32'h80, 4'd4, 0, 0, 32'h0));
            apply(mk(0, OP_NONE, 5'd0, 32'h0, 3'd0,  3'b000, 32'h0,             0, 0, 32'h80, 4'd4, 0, 0, 32'h0));
        end
        apply(mk(0, OP_NONE, 5'd0,      32'h0, c_oor, 3'b000, 32'h2000, 1, 1, 32'h80,   4'd4, 1, 0, 32'h0));
        apply(mk(0, OP_MFC,  REG_LEVEL, 32'h0, 3'd0,  3'b000, 32'h0,    0, 0, 32'h80,   4'd4, 1, 1, 32'hC4));
        apply(mk(0, OP_ERET, 5'd0,      32'h0, 3'd0,  3'b000, 32'h0,    1, 0, 32'h2000, 4'd4, 1, 0, 32'h0));
        apply(mk(0, OP_MFC,  REG_EPC,   32'h0, 3'd0,  3'b000, 32'h0,    0, 0, 32'h2000, 4'd4, 1, 1, 32'h1002));
        apply(mk(0, OP_MTC,  REG_CAUSE, 32'h0, 3'd0,  3'b000, 32'h0,    0, 0, 32'h2000, 4'd4, 0, 0, 32'h0));
        apply(mk(0, OP_ERET, 5'd0,      32'h0, 3'd0,  3'b000, 32'h0,    1, 0, 32'h1002, 4'd4, 0, 0, 32'h0));
        apply(mk(0, OP_NONE, 5'd0,      32'h0, 3'd0,  3'b000, 32'h0,    0, 0, 32'h1002, 4'd4, 0, 0, 32'h0));
        apply(mk(0, OP_ERET, 5'd0,      32'h0, 3'd0,  3'b000, 32'h0,    1, 0, 32'h1001, 4'd4, 0, 0, 32'h0));
        apply(mk(0, OP_NONE, 5'd0,      32'h0, 3'd0,  3'b000, 32'h0,    0, 0, 32'h1001, 4'd4, 0, 0, 32'h0));
        apply(mk(0, OP_ERET, 5'd0,      32'h0, 3'd0,  3'b000, 32'h0,    1, 0, 32'h1000, 4'd0, 0, 0, 32'h0));
        apply(mk(0, OP_MFC,  REG_LEVEL, 32'h0, 3'd0,  3'b000, 32'h0,    0, 0, 32'h1000, 4'd0, 0, 1, 32'h0));

        // reset during the redirect cycle aborts it and empties everything
        apply(mk(0, OP_NONE, 5'd0,       32'h0, 3'd0, 3'b001, 32'h500, 1, 1, 32'h80, 4'd1, 0, 0, 32'h0));
        apply(mk(1, OP_NONE, 5'd0,       32'h0, 3'd0, 3'b000, 32'h0,   0, 0, 32'h24, 4'd0, 0, 0, 32'h0));
        apply(mk(0, OP_MFC,  REG_LEVEL,  32'h0, 3'd0, 3'b000, 32'h0,   0, 0, 32'h24, 4'd0, 0, 1, 32'h0));
        apply(mk(0, OP_MFC,  REG_EHB,    32'h0, 3'd0, 3'b000, 32'h0,   0, 0, 32'h24, 4'd0, 0, 1, 32'h24));
        apply(mk(0, OP_MFC,  REG_STATUS, 32'h0, 3'd0, 3'b001, 32'h0,   0, 0, 32'h24, 4'd0, 0, 1, 32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_nested_irq.md
Name: cp0_nested_irq

Overview:
Parametrised coprocessor-0 successor for the pipelined MIPS core. It handles CP0 register access (mtc0/mfc0), synchronous exceptions, and NUM_IRQ maskable prioritised interrupt lines with true nesting. A return-address/level LIFO makes eret restore the interrupted level correctly. It sits beside ID/EXE and drives the PC-redirect and pipeline-flush signals.

Parameters:
DATA_W, 32, register/address width
NUM_IRQ, 3, interrupt lines; line k has priority level k+1 (max 8)
NEST_DEPTH, 4, LIFO entries (power of 2)
EHB_RESET, 32'h0000_0024, reset value of handler-base register
EXC_W, 3, width of exception cause code

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cp_oper  in  3  0 none, 1 mtc, 2 mfc, 3 eret
addr_r  in  5  mfc register index
data_readFromCP0  out  DATA_W  mfc result, registered
addr_w  in  5  mtc register index
data_writeToCP0  in  DATA_W  mtc data
cause  in  EXC_W  exception code, 0 = none
interruptSignal  in  NUM_IRQ  level-sensitive interrupt lines
except_ret_addr  in  DATA_W  return address to save on trap
epc_ctrl  out  1  one-cycle PC-redirect strobe
jumpAddressExcept  out  DATA_W  redirect target
exceptClear  out  1  one-cycle pipeline flush strobe (traps only)
cur_level  out  4  current priority level (0 user, NUM_IRQ+1 exception)
nest_overflow  out  1  sticky LIFO overflow flag

Behaviour:
- Registers: EHB=3, STATUS=12, CAUSE=13, EPC=14, LEVEL=15 (read-only {nest_overflow, depth, cur_level}). The remaining indices are plain storage.
- Reset: all registers 0 except EHB=EHB_RESET. Outputs: epc_ctrl=0, exceptClear=0, data_readFromCP0=0, jumpAddressExcept=EHB_RESET, cur_level=0, nest_overflow=0. LIFO is emptied and FSM goes to RUN. A reset asserted mid-redirect aborts the redirect.
- STATUS[0]=IE (global enable). STATUS[8+k]=mask enable for line k.
- pend[k] = interruptSignal[k] & STATUS[8+k] & IE. L = highest pending level.
- FSM has two states: RUN and REDIR.
- RUN, evaluated in this priority order:
  1. Exception (cause!=0 & IE):
     - Push {except_ret_addr, cur_level}. EPC <= except_ret_addr.
     - CAUSE <= {1'b0, sampled interruptSignal at [8+:NUM_IRQ], cause at [EXC_W-1:0]}.
     - cur_level <= NUM_IRQ+1. jumpAddressExcept <= EHB.
     - Next cycle: epc_ctrl=1, exceptClear=1. Go to REDIR.
  2. Otherwise, interrupt (L > cur_level and LIFO not full):
     - Same push, EPC and redirect actions as an exception.
     - CAUSE[31]=1, CAUSE[EXC_W-1:0]=0. cur_level <= L.
     - If L <= cur_level or the LIFO is full: no action; the line stays pending.
  3. Otherwise, eret:
     - If the LIFO is non-empty: pop; jumpAddressExcept <= popped addr; cur_level <= popped level; EPC <= new top addr (0 if now empty).
     - If the LIFO is empty: jump to EPC, cur_level <= 0.
     - Next cycle: epc_ctrl=1, exceptClear=0. Go to REDIR.
- Exception with LIFO full: the top entry is overwritten and nest_overflow is set. nest_overflow clears only on reset or on an mtc to CAUSE.
- REDIR lasts exactly 1 cycle, then returns to RUN.
  - cause and eret are ignored (they come from flushed instructions).
  - Interrupts are not accepted; they are re-evaluated in RUN.
- mtc and mfc are honoured in both states, concurrent with traps.
  - A trap's writes to EPC/CAUSE override a same-cycle mtc to those registers.
  - mtc to EPC also rewrites the LIFO top address, if the LIFO is non-empty.
  - mtc to LEVEL is ignored.
- mfc: data_readFromCP0 <= reg[addr_r] one cycle later. A read of a register written by mtc in the same cycle returns the old value.
- epc_ctrl and exceptClear are never high for two consecutive cycles.

Decomposition:
- Package cp0_pkg: cp_oper encodings, register indices, cause codes (Undefined=1, Overflow=2, OutOfRange=4), the FSM state enum, and the CAUSE field positions.
- Sub-module cp0_epc_stack: a LIFO of {DATA_W addr, 4-bit level}.
  - Ports: push, pop, wr_top, top, depth, full, empty.
  - Overwrite-on-full is selected by a port input.

Test Plan:
1. Reset, mfc 3 -> data 0x24 one cycle later; cur_level 0; epc_ctrl 0.
2. mtc STATUS=0x0000_0701, raise irq line 0 with ret 0x100 -> next cycle epc_ctrl=1, jump 0x24, exceptClear=1, cur_level 1, EPC 0x100.
3. From 2, raise line 2 with ret 0x200 -> nested trap, cur_level 3. eret -> jump 0x200, level 1, EPC 0x100. eret -> jump 0x100, level 0.
4. Level 3 active, raise line 1 -> no redirect. Same cycle cause=2 with ret 0x300 -> trap, CAUSE[2:0]=2, cur_level 4. cause=1 held in REDIR -> ignored.
5. Fill LIFO with NEST_DEPTH traps, then one more exception -> nest_overflow=1 with top overwritten. mtc CAUSE -> nest_overflow=0.
6. rst asserted on the cycle after a trap -> epc_ctrl 0, cur_level 0, LIFO empty, jump 0x24.
